// File: rtl/sr_ff_driver.sv
// Request-driven S/R pulse generator for an external SR flip-flop.
// Drives Q to a target value, verifies via readback with bounded retries, then holds.
module sr_ff_driver #(
  parameter int unsigned HOLD_W    = 8,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned RETRY_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_val,
  input  logic               req_force,
  input  logic [HOLD_W-1:0]  req_hold,
  input  logic               q_fb,
  output logic               S,
  output logic               R,
  output logic               busy,
  output logic               done,
  output logic               err,
  input  logic               clr_err,
  output logic [RETRY_W-1:0] retries
);

  localparam logic [RETRY_W-1:0] MaxRetry = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StCheck,
    StHold,
    StError
  } state_e;

  state_e              state_q, state_d;
  logic                target_q, target_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0]  retries_q, retries_d;
  logic                s_q, s_d;
  logic                r_q, r_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    retries_d = retries_q;
    err_d     = err_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          target_d  = req_val;
          hold_d    = req_hold;
          retries_d = '0;
          // Already at target and not forced: skip the pulse entirely.
          if (!req_force && (q_fb == req_val)) begin
            state_d = StHold;
            cnt_d   = req_hold;
          end else begin
            state_d = StDrive;
          end
        end
      end
      StDrive: state_d = StCheck;
      StCheck: begin
        if (q_fb == target_q) begin
          state_d = StHold;
          cnt_d   = hold_q;
        end else if (retries_q < MaxRetry) begin
          retries_d = retries_q + RETRY_W'(1);
          state_d   = StDrive;
        end else begin
          err_d   = 1'b1;
          state_d = StError;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      StError: begin
        if (clr_err) begin
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Pulses are registered from the next state so S/R are high exactly while in DRIVE.
    s_d    = (state_d == StDrive) &  target_d;
    r_d    = (state_d == StDrive) & ~target_d;
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      target_q  <= 1'b0;
      hold_q    <= '0;
      cnt_q     <= '0;
      retries_q <= '0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      retries_q <= retries_d;
      s_q       <= s_d;
      r_q       <= r_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign S         = s_q;
  assign R         = r_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign retries   = retries_q;

endmodule

// File: tb/tb_sr_ff_driver.sv
// Scoreboard bench for sr_ff_driver against a behavioural SR flip-flop model
// with stuck-at-0 and ignore-N-pulses feedback modes.
module tb_sr_ff_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_val, req_force;
  logic [7:0] req_hold;
  logic       q_fb, S, R, busy, done, err, clr_err;
  logic [1:0] retries;

  sr_ff_driver #(
    .HOLD_W   (8),
    .MAX_RETRY(3),
    .RETRY_W  (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_val  (req_val),
    .req_force(req_force),
    .req_hold (req_hold),
    .q_fb     (q_fb),
    .S        (S),
    .R        (R),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .clr_err  (clr_err),
    .retries  (retries)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int s_cnt    = 0;
  int r_cnt    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Flip-flop model: preset port, stuck-at-0 override, and N ignored pulses.
  bit q_ff = 1'b0;
  bit preset_en = 1'b0, preset_val = 1'b0, stuck0 = 1'b0;
  int preset_ign = 0, ign_left = 0;

  always @(posedge clk) begin
    if (preset_en) begin
      q_ff     <= preset_val;
      ign_left <= preset_ign;
    end else if (S || R) begin
      if (ign_left != 0) ign_left <= ign_left - 1;
      else               q_ff     <= S;
    end
  end
  assign q_fb = stuck0 ? 1'b0 : q_ff;

  typedef struct {
    bit val;
    bit is_err;
    int ret;
    int lat;
    int acc;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on done or a rising err, plus per-cycle invariants.
  bit err_prev = 1'b0;
  always @(negedge clk) begin
    exp_t x;
    if (S) s_cnt++;
    if (R) r_cnt++;
    if (!rst) begin
      chk("s_and_r", int'(S & R), 0);
      chk("ready_vs_busy", int'(req_ready), int'(!busy));
      if (done || (err && !err_prev)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", 1, 0);
        end else begin
          x = exp_q.pop_front();
          chk("completion_kind", int'(err), int'(x.is_err));
          chk("latency", cyc - x.acc, x.lat);
          chk("retries", int'(retries), x.ret);
          if (!x.is_err) chk("q_at_done", int'(q_fb), int'(x.val));
        end
      end
    end
    err_prev = err;
  end

  task automatic preset(input bit v, input int ign);
    @(negedge clk);
    preset_en = 1'b1; preset_val = v; preset_ign = ign;
    @(posedge clk);
    #1 preset_en = 1'b0;
  endtask

  task automatic issue(input bit v, input bit f, input int h, input bit e_err,
                       input int e_ret, input int e_lat);
    exp_t x;
    int   n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    req_valid = 1'b1; req_val = v; req_force = f; req_hold = 8'(h);
    x.val = v; x.is_err = e_err; x.ret = e_ret; x.lat = e_lat; x.acc = cyc + 1;
    exp_q.push_back(x);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int s0, r0, h;
    bit v, f;
    rst = 1'b1; req_valid = 1'b0; req_val = 1'b0; req_force = 1'b0; req_hold = '0;
    clr_err = 1'b0;
    preset(1'b0, 0);
    @(negedge clk);
    chk("rst_S", int'(S), 0);
    chk("rst_R", int'(R), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_retries", int'(retries), 0);
    chk("rst_ready", int'(req_ready), 1);
    #1 rst = 1'b0;

    // 1: drive 0 -> 1, no hold.
    s0 = s_cnt; r0 = r_cnt;
    issue(1'b1, 1'b0, 0, 1'b0, 0, 3);
    drain();
    chk("t1_s_pulses", s_cnt - s0, 1);
    chk("t1_r_pulses", r_cnt - r0, 0);

    // 2: already at target, no pulse; then forced.
    s0 = s_cnt; r0 = r_cnt;
    issue(1'b1, 1'b0, 2, 1'b0, 0, 3);
    drain();
    chk("t2a_pulses", (s_cnt - s0) + (r_cnt - r0), 0);
    s0 = s_cnt;
    issue(1'b1, 1'b1, 2, 1'b0, 0, 5);
    drain();
    chk("t2b_s_pulses", s_cnt - s0, 1);

    // 3: stuck feedback exhausts retries.
    preset(1'b0, 0);
    stuck0 = 1'b1;
    s0 = s_cnt;
    issue(1'b1, 1'b0, 0, 1'b1, 3, 8);
    drain();
    chk("t3_s_pulses", s_cnt - s0, 4);
    chk("t3_err", int'(err), 1);
    chk("t3_ready", int'(req_ready), 0);
    chk("t3_busy", int'(busy), 1);
    repeat (3) @(negedge clk);
    chk("t3_err_sticky", int'(err), 1);
    clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    @(negedge clk);
    chk("t3_err_cleared", int'(err), 0);
    chk("t3_ready_after_clr", int'(req_ready), 1);
    chk("t3_retries_held", int'(retries), 3);
    stuck0 = 1'b0;

    // 4: first pulse ignored, drive 1 -> 0.
    preset(1'b1, 1);
    r0 = r_cnt;
    issue(1'b0, 1'b0, 0, 1'b0, 1, 5);
    drain();
    chk("t4_r_pulses", r_cnt - r0, 2);
    chk("t4_err", int'(err), 0);

    // 5: reset during DRIVE; no completion may follow.
    @(negedge clk);
    req_valid = 1'b1; req_val = ~q_fb; req_force = 1'b1; req_hold = 8'd1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("t5_in_drive", int'(S | R), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_S", int'(S), 0);
    chk("t5_R", int'(R), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_err", int'(err), 0);
    chk("t5_retries", int'(retries), 0);
    #1 rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("t5_stays_idle", int'(busy), 0);

    // 6: back-to-back requests against a live flip-flop.
    preset(1'b0, 0);
    for (int i = 0; i < 24; i++) begin
      v = 1'($urandom_range(0, 1));
      f = 1'($urandom_range(0, 1));
      h = int'($urandom_range(0, 3));
      @(negedge clk);
      while (!req_ready) @(negedge clk);
      // q_fb is stable while idle, so the routing decision is known here.
      if (!f && (q_fb == v)) issue(v, f, h, 1'b0, 0, 1 + h);
      else                   issue(v, f, h, 1'b0, 0, 3 + h);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sr_ff_driver.md
Name: sr_ff_driver

Overview:
Control-side counterpart to the team's SR flip-flop. It accepts "drive Q to value V" requests on a valid/ready handshake and generates one-cycle S or R pulses to the flip-flop. It then reads the flip-flop's Q back and confirms the update, retrying on mismatch. After a confirmed update it holds the value for a programmable minimum time. It sits between control logic and any SR flip-flop instance, and guarantees the invalid S=R=1 combination is never driven.

Parameters:
HOLD_W, 8, width of per-request minimum hold count
MAX_RETRY, 3, drive attempts after the first before declaring error (1..2^RETRY_W-1)
RETRY_W, 2, width of retry counter/output

Ports:
clk  input  1  rising-edge clock, shared with the driven flip-flop
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  driver can accept request
req_val  input  1  target Q value
req_force  input  1  issue pulse even if q_fb already equals req_val
req_hold  input  HOLD_W  cycles to hold after confirmation (0 = none)
q_fb  input  1  Q readback from the flip-flop
S  output  1  set pulse to flip-flop
R  output  1  reset pulse to flip-flop
busy  output  1  high when state != IDLE
done  output  1  one-cycle pulse on request completion
err  output  1  sticky failure flag
clr_err  input  1  clears err, returns ERROR->IDLE
retries  output  RETRY_W  retries used by current/last request

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). rst has priority over all other inputs.
- Reset values: S=0, R=0, done=0, err=0, busy=0, retries=0, state=IDLE, internal target/hold registers=0. A mid-operation reset drops S/R at that edge. No completion is reported.
- All outputs are registered. req_ready = (state==IDLE), combinational from state.
- Accept: req_valid & req_ready at a clock edge. The edge latches req_val, req_hold and req_force, and clears retries.
- Accept routing:
  - If !req_force and q_fb==req_val at the accept edge: no pulse is issued and the state goes to HOLD.
  - Otherwise the state goes to DRIVE.
- DRIVE (1 cycle): S=target, R=~target. Next state is CHECK.
- CHECK (1 cycle): S=R=0. The flip-flop sampled the pulse at the end of DRIVE, so q_fb is valid here.
  - q_fb==target: next state HOLD.
  - Mismatch and retries<MAX_RETRY: retries+1, next state DRIVE.
  - Mismatch and retries==MAX_RETRY: err=1, next state ERROR.
- HOLD: a counter loads req_hold on entry and decrements each cycle. HOLD exits on the cycle the count is 0. With req_hold=0, HOLD lasts 1 cycle. On exit, done=1 for one cycle and the state goes to IDLE. HOLD lasts req_hold+1 cycles total.
- ERROR: S=R=0, req_ready=0, err stays high. clr_err=1 clears err and returns the state to IDLE on the next edge. clr_err is ignored in other states.
- Latency, accept edge to done pulse: 3+req_hold cycles with no retries. Each retry adds 2 cycles.
- Invariant: S&R is never 1. S and R are each high only in DRIVE, for exactly one cycle per attempt.
- req_valid deasserted without acceptance has no effect. Request inputs are ignored while busy.
- retries holds its value after done or err until the next accept.

Test Plan:
1. q_fb=0, request req_val=1, hold=0 -> S=1 for exactly the cycle after accept, R=0 throughout, done 3 cycles after accept, retries=0.
2. q_fb=1, request req_val=1, force=0, hold=2 -> S=R=0 throughout, done 3 cycles after accept (HOLD 3 cycles). Repeat with force=1 -> S pulse issued, done 5 cycles after accept.
3. q_fb tied to 0, request req_val=1 -> 4 S pulses, each 2 cycles apart, retries=3, err=1, state ERROR, req_ready=0. Then clr_err -> err=0, req_ready=1 next cycle.
4. Feedback model that ignores the first pulse, request req_val=0 from Q=1 -> 2 R pulses, retries=1, done 5 cycles after accept, err=0.
5. rst asserted during DRIVE -> S=R=0, busy=0, done=0, err=0, retries=0 after that edge. No done pulse afterwards.
6. Randomized back-to-back requests with a live SR flip-flop model -> S&R never 1, q_fb equals target at every done, req_ready low whenever busy.
